// File: rtl/multdiv_step_counter_pkg.sv
// +--------------------------------------------------------------------+
// | multdiv_step_counter_pkg : shared multdiv state and mode constants  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package multdiv_step_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/multdiv_step_counter_if.sv
// +--------------------------------------------------------------------+
// | multdiv_step_counter_if : control/status bundle of the step counter |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface multdiv_step_counter_if #(
    parameter int WIDTH = 6
);
    logic             start;
    logic             abort;
    logic             hold;
    logic             down;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             last;
    logic             done;

    modport master (
        output start, abort, hold, down, limit,
        input  count, busy, last, done
    );

    modport slave (
        input  start, abort, hold, down, limit,
        output count, busy, last, done
    );
endinterface

`default_nettype wire

// File: rtl/multdiv_step_counter_step_count_reg.sv
// +--------------------------------------------------------------------+
// | step_count_reg : loadable up/down count register, async clear      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module step_count_reg #(
    parameter int WIDTH = 6
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             clr_i,
    input  wire logic             load_i,
    input  wire logic [WIDTH-1:0] load_val_i,
    input  wire logic             en_i,
    input  wire logic             down_i,
    output logic      [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = down_i ? (count_q - 1'b1) : (count_q + 1'b1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/multdiv_step_counter.sv
// +--------------------------------------------------------------------+
// | multdiv_step_counter : bounded up/down iteration counter with       |
// | start/done handshake, hold and abort.   Rev 1.0                     |
// +--------------------------------------------------------------------+
`default_nettype none

module multdiv_step_counter
    import multdiv_step_counter_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  wire logic              clock_i,
    input  wire logic              reset_ni,
    multdiv_step_counter_if.slave  bus
);

    state_e           state_q;
    logic [WIDTH-1:0] limit_q;
    logic             mode_q;

    logic [WIDTH-1:0] count_w;
    logic [WIDTH-1:0] terminal_w;
    logic             at_term_w;
    logic             accept_w;
    logic             clr_w;
    logic             step_w;
    logic [WIDTH-1:0] load_val_w;

    // Abort outranks start, so a start coinciding with abort is dropped.
    assign accept_w   = bus.start && !bus.abort &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign terminal_w = (mode_q == MODE_DOWN) ? '0 : limit_q;
    assign at_term_w  = (count_w == terminal_w);
    assign clr_w      = bus.abort && (state_q != ST_IDLE);
    assign step_w     = (state_q == ST_RUN) && !bus.abort && !bus.hold && !at_term_w;
    assign load_val_w = (bus.down == MODE_DOWN) ? bus.limit : '0;

    step_count_reg #(
        .WIDTH (WIDTH)
    ) u_count (
        .clk_i      (clock_i),
        .rst_ni     (reset_ni),
        .clr_i      (clr_w),
        .load_i     (accept_w),
        .load_val_i (load_val_w),
        .en_i       (step_w),
        .down_i     (mode_q),
        .count_o    (count_w)
    );

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            limit_q <= '0;
            mode_q  <= MODE_UP;
        end else begin
            if (accept_w) begin
                limit_q <= bus.limit;
                mode_q  <= bus.down;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept_w) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.abort)                  state_q <= ST_IDLE;
                    else if (!bus.hold && at_term_w) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= accept_w ? ST_RUN : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.count = count_w;
    assign bus.busy  = (state_q == ST_RUN);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.last  = (state_q == ST_RUN) && at_term_w;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_step_counter.sv
// +--------------------------------------------------------------------+
// | tb_multdiv_step_counter : scoreboard bench for the step counter     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_multdiv_step_counter;

    localparam int W = 6;

    typedef struct packed {
        logic [W-1:0] c;
        logic         l;
    } exp_t;

    logic   clock;
    logic   reset_n;
    exp_t   sbq[$];
    int     n_pass  = 0;
    int     n_total = 0;

    multdiv_step_counter_if #(.WIDTH(W)) bus ();

    multdiv_step_counter #(.WIDTH(W)) dut (
        .clock_i  (clock),
        .reset_ni (reset_n),
        .bus      (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        n_total++;
        if (act !== exp_v) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        else n_pass++;
    endtask

    // Pushes the expected RUN-cycle sequence, then drives the start edge.
    task automatic launch(input int lim, input bit dn, input int hcnt, input int hn, input int mid_lim);
        exp_t e;
        int   v;
        int   term;
        term = dn ? 0 : lim;
        for (int i = 0; i <= lim; i++) begin
            v   = dn ? (lim - i) : i;
            e.c = v[W-1:0];
            e.l = (v == term);
            sbq.push_back(e);
            if (i == hcnt) for (int k = 0; k < hn; k++) sbq.push_back(e);
        end
        bus.start = 1'b1;
        bus.limit = lim[W-1:0];
        bus.down  = dn;
        tick();
        bus.start = 1'b0;
        bus.limit = mid_lim[W-1:0];
        bus.down  = ~dn;
    endtask

    task automatic drain(input string nm, input int lim, input bit dn, input int hcnt,
                         input int hn, input bit settle);
        exp_t e;
        int   idx = 0;
        int   term;
        term = dn ? 0 : lim;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({nm, " busy"}, {{(W-1){1'b0}}, bus.busy}, 1);
            chk({nm, " count"}, bus.count, e.c);
            chk({nm, " last"}, {{(W-1){1'b0}}, bus.last}, {{(W-1){1'b0}}, e.l});
            chk({nm, " done-early"}, {{(W-1){1'b0}}, bus.done}, 0);
            bus.hold = (hcnt >= 0) && (idx >= hcnt) && (idx < hcnt + hn);
            tick();
            idx++;
        end
        bus.hold = 1'b0;
        chk({nm, " done"}, {{(W-1){1'b0}}, bus.done}, 1);
        chk({nm, " busy@done"}, {{(W-1){1'b0}}, bus.busy}, 0);
        chk({nm, " count@done"}, bus.count, term[W-1:0]);
        if (settle) begin
            tick();
            chk({nm, " done-once"}, {{(W-1){1'b0}}, bus.done}, 0);
            chk({nm, " idle-busy"}, {{(W-1){1'b0}}, bus.busy}, 0);
            chk({nm, " idle-count"}, bus.count, term[W-1:0]);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.hold  = 1'b0;
        bus.down  = 1'b0;
        bus.limit = '0;
        #1;
        chk("reset count", bus.count, 0);
        chk("reset busy", {{(W-1){1'b0}}, bus.busy}, 0);
        chk("reset last", {{(W-1){1'b0}}, bus.last}, 0);
        chk("reset done", {{(W-1){1'b0}}, bus.done}, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("post-reset busy", {{(W-1){1'b0}}, bus.busy}, 0);
    endtask

    task automatic test_up31();
        launch(31, 1'b0, -1, 0, 31);
        drain("up31", 31, 1'b0, -1, 0, 1'b1);
    endtask

    task automatic test_down5();
        launch(5, 1'b1, -1, 0, 5);
        drain("down5", 5, 1'b1, -1, 0, 1'b1);
    endtask

    task automatic test_hold();
        launch(3, 1'b0, 1, 2, 9);
        drain("hold", 3, 1'b0, 1, 2, 1'b1);
    endtask

    task automatic test_abort();
        launch(10, 1'b0, -1, 0, 10);
        for (int i = 0; i < 4; i++) begin
            chk("abort pre-count", bus.count, i[W-1:0]);
            tick();
        end
        chk("abort at4", bus.count, 4);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        sbq.delete();
        chk("abort busy", {{(W-1){1'b0}}, bus.busy}, 0);
        chk("abort count", bus.count, 0);
        for (int i = 0; i < 3; i++) begin
            chk("abort no-done", {{(W-1){1'b0}}, bus.done}, 0);
            tick();
        end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.limit = 6'd4;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start+abort busy", {{(W-1){1'b0}}, bus.busy}, 0);
        chk("start+abort count", bus.count, 0);
    endtask

    task automatic test_back_to_back();
        launch(0, 1'b0, -1, 0, 0);
        drain("lim0", 0, 1'b0, -1, 0, 1'b0);
        launch(2, 1'b0, -1, 0, 2);
        drain("b2b", 2, 1'b0, -1, 0, 1'b1);
    endtask

    task automatic test_async_reset();
        launch(20, 1'b0, -1, 0, 20);
        for (int i = 0; i < 7; i++) tick();
        sbq.delete();
        chk("arst pre-count", bus.count, 7);
        #2 reset_n = 1'b0;
        #1;
        chk("arst count", bus.count, 0);
        chk("arst busy", {{(W-1){1'b0}}, bus.busy}, 0);
        chk("arst done", {{(W-1){1'b0}}, bus.done}, 0);
        tick();
        chk("arst held done", {{(W-1){1'b0}}, bus.done}, 0);
        reset_n = 1'b1;
        tick();
        chk("arst released busy", {{(W-1){1'b0}}, bus.busy}, 0);
        chk("arst released done", {{(W-1){1'b0}}, bus.done}, 0);
        launch(4, 1'b1, -1, 0, 4);
        drain("arst rerun", 4, 1'b1, -1, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_up31();
        test_down5();
        test_hold();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multdiv_step_counter.md
Name: multdiv_step_counter

Overview:
Parametrised iteration counter for the multdiv sequencers, generalising the fixed 5-bit free-running step counter. It runs a bounded count with a start/done handshake and a programmable terminal value, counting up or down. Hold and abort let the multiplier and divider datapaths stall or cancel an operation. The multiplier uses it up-counting with limit=31; the divider uses it down-counting.

Parameters:
WIDTH, 6, width of count and limit; the maximum run is 2^WIDTH steps.

Ports:
clock  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
start  input  1  requests a new run; sampled only in IDLE or DONE.
abort  input  1  cancels the current run; highest priority after reset.
hold   input  1  stalls stepping while in RUN.
down   input  1  mode captured at start: 0 = count 0 up to limit; 1 = count limit down to 0.
limit  input  WIDTH  terminal value captured at start.
count  output WIDTH  current step index.
busy   output 1  high while in RUN.
last   output 1  high during the final RUN cycle: count equals the terminal value.
done   output 1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; count=0; latched limit=0; latched mode=up.
  - busy=0, last=0, done=0; these hold until the first rising edge after release.
- States: IDLE, RUN, DONE. busy is high only in RUN; done is high only in DONE.
- Terminal value: latched limit in up mode, 0 in down mode.
- last = (state==RUN) && (count==terminal). It is combinational from registers and independent of hold.
- IDLE:
  - count holds.
  - start=1: latch limit and down; count := 0 (up) or limit (down); go to RUN.
- RUN:
  - abort=1: go to IDLE; count := 0; no done pulse.
  - else hold=1: no change.
  - else count==terminal: go to DONE; count holds.
  - else count := count+1 (up) or count-1 (down).
- DONE:
  - done=1 for exactly this cycle.
  - Next state is IDLE, or RUN if start=1 (back-to-back restart, same load rules as IDLE).
  - abort=1 in DONE: go to IDLE, count := 0. The done pulse of this cycle still appears.
- Priority at each edge: reset > abort > start > hold > step.
- start is ignored while in RUN.
- limit and down are ignored outside the start-accept edge. Mid-run changes have no effect.
- Latency, no hold:
  - Start accepted at edge E; RUN holds limit+1 cycles, each step value appearing for one cycle.
  - done is high in the cycle after edge E+limit+1.
  - Each hold cycle in RUN adds exactly one cycle.
- limit=0: one RUN cycle with last=1, then DONE.
- limit=2^WIDTH-1, up mode: count reaches all-ones and never wraps. Stepping past the terminal value is impossible.
- Reset asserted mid-RUN: the run is discarded, no done pulse, and the block returns to the reset state.

Decomposition:
- Shared multdiv constants include: state encodings ST_IDLE, ST_RUN, ST_DONE (2 bits) and mode constants MODE_UP=0, MODE_DOWN=1.
- One natural sub-module: step_count_reg, a WIDTH-bit loadable up/down register with enable and async active-low clear.
- The FSM, terminal compare, latches and output decode stay in the top module.

Test Plan:
- Reset, then start with limit=31, down=0:
  - count steps 0..31 over 32 RUN cycles; last=1 only at count=31.
  - done pulses once, 33 cycles after start was sampled; count stays 31 in IDLE.
- Start with limit=5, down=1: count 5,4,3,2,1,0; last=1 at 0; done one cycle later; busy high for 6 cycles.
- limit=3, up mode, hold high for 2 cycles while count=1:
  - count sequence 0,1,1,1,2,3; done is delayed by exactly 2 cycles.
  - Change limit to 9 mid-run: terminal stays 3.
- Abort at count=4 during a limit=10 run: next cycle is IDLE with count=0 and busy=0, and done never pulses. Raising start and abort together in IDLE stays in IDLE.
- limit=0: one RUN cycle with count=0 and last=1, then done. Asserting start during DONE restarts immediately, with busy high the cycle after done.
- Pull reset low asynchronously between edges mid-run at count=7: count=0 and busy=0 immediately, no done pulse; a normal run follows after release.
